// File: rtl/dpram_access_arbiter.sv
// -----------------------------------------------------------------------------
// dpram_access_arbiter
//
// Synchronous front end for an asynchronous dual-port RAM. Two client request
// channels (A, B) are mapped onto RAM Port A and Port B. All RAM-side strobes
// are registered. Same-address hazards (both valid, same address, at least one
// write) are serialised by a two-state round-robin priority pointer, so the
// RAM never sees a same-address write collision. Read data is captured one
// cycle after issue into a valid-tagged response per client. A saturating
// counter records every serialised hazard.
//
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   req_valid_x / req_ready_x         request handshake (ready is combinational)
//   req_we_x, req_addr_x, req_wdata_x request attributes (x = a, b)
//   rsp_valid_x, rsp_rdata_x          one-cycle read response
//   ram_addr_x, ram_din_x,
//   ram_we_x, ram_re_x                registered RAM port drive
//   ram_dout_x                        RAM read data
//   hazard_cnt                        saturating serialised-hazard count
// -----------------------------------------------------------------------------
module dpram_access_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 8,
  parameter bit A_FIRST    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid_a,
  output logic                  req_ready_a,
  input  logic                  req_we_a,
  input  logic [ADDR_WIDTH-1:0] req_addr_a,
  input  logic [DATA_WIDTH-1:0] req_wdata_a,
  output logic                  rsp_valid_a,
  output logic [DATA_WIDTH-1:0] rsp_rdata_a,
  input  logic                  req_valid_b,
  output logic                  req_ready_b,
  input  logic                  req_we_b,
  input  logic [ADDR_WIDTH-1:0] req_addr_b,
  input  logic [DATA_WIDTH-1:0] req_wdata_b,
  output logic                  rsp_valid_b,
  output logic [DATA_WIDTH-1:0] rsp_rdata_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  output logic                  ram_we_a,
  output logic                  ram_re_a,
  input  logic [DATA_WIDTH-1:0] ram_dout_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_din_b,
  output logic                  ram_we_b,
  output logic                  ram_re_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b,
  output logic [CNT_WIDTH-1:0]  hazard_cnt
);

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_e;

  localparam pri_e PRI_RST = A_FIRST ? PRI_A : PRI_B;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  pri_e                  pri_q, pri_d;
  logic                  hazard_s;
  logic                  ready_a_s, ready_b_s;
  logic                  acc_a_s, acc_b_s;

  logic [CNT_WIDTH-1:0]  hazard_cnt_q, hazard_cnt_d;
  logic [ADDR_WIDTH-1:0] ram_addr_a_q, ram_addr_a_d, ram_addr_b_q, ram_addr_b_d;
  logic [DATA_WIDTH-1:0] ram_din_a_q, ram_din_a_d, ram_din_b_q, ram_din_b_d;
  logic                  ram_we_a_q, ram_we_a_d, ram_we_b_q, ram_we_b_d;
  logic                  ram_re_a_q, ram_re_a_d, ram_re_b_q, ram_re_b_d;
  logic                  rsp_valid_a_q, rsp_valid_a_d, rsp_valid_b_q, rsp_valid_b_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_a_q, rsp_rdata_a_d, rsp_rdata_b_q, rsp_rdata_b_d;

  // Hazard detection and request acceptance; two reads never collide.
  always_comb begin
    hazard_s  = req_valid_a & req_valid_b & (req_addr_a == req_addr_b) &
                (req_we_a | req_we_b);
    ready_a_s = 1'b0;
    ready_b_s = 1'b0;
    if (!reset_n) begin
      ready_a_s = 1'b0;
      ready_b_s = 1'b0;
    end else if (hazard_s) begin
      ready_a_s = (pri_q == PRI_A);
      ready_b_s = (pri_q == PRI_B);
    end else begin
      ready_a_s = 1'b1;
      ready_b_s = 1'b1;
    end
    acc_a_s = req_valid_a & ready_a_s;
    acc_b_s = req_valid_b & ready_b_s;
  end

  // Priority pointer next state: a hazard hands priority to the loser, so a
  // held-off request always wins on the following cycle.
  always_comb begin
    pri_d = pri_q;
    case (pri_q)
      PRI_A: begin
        if (hazard_s) pri_d = PRI_B;
        else          pri_d = PRI_A;
      end
      PRI_B: begin
        if (hazard_s) pri_d = PRI_A;
        else          pri_d = PRI_B;
      end
      default: pri_d = PRI_RST;
    endcase
  end

  // Saturating hazard counter next state.
  always_comb begin
    hazard_cnt_d = hazard_cnt_q;
    if (hazard_s && (hazard_cnt_q != CNT_MAX)) begin
      hazard_cnt_d = hazard_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      hazard_cnt_d = hazard_cnt_q;
    end
  end

  // RAM port issue: strobes last exactly one cycle, address/data hold when idle.
  always_comb begin
    ram_we_a_d   = acc_a_s & req_we_a;
    ram_re_a_d   = acc_a_s & ~req_we_a;
    ram_we_b_d   = acc_b_s & req_we_b;
    ram_re_b_d   = acc_b_s & ~req_we_b;
    ram_addr_a_d = ram_addr_a_q;
    ram_din_a_d  = ram_din_a_q;
    ram_addr_b_d = ram_addr_b_q;
    ram_din_b_d  = ram_din_b_q;
    if (acc_a_s) begin
      ram_addr_a_d = req_addr_a;
      ram_din_a_d  = req_wdata_a;
    end else begin
      ram_addr_a_d = ram_addr_a_q;
      ram_din_a_d  = ram_din_a_q;
    end
    if (acc_b_s) begin
      ram_addr_b_d = req_addr_b;
      ram_din_b_d  = req_wdata_b;
    end else begin
      ram_addr_b_d = ram_addr_b_q;
      ram_din_b_d  = ram_din_b_q;
    end
  end

  // Read response capture: data sampled at the end of the issue cycle.
  always_comb begin
    rsp_valid_a_d = ram_re_a_q;
    rsp_valid_b_d = ram_re_b_q;
    rsp_rdata_a_d = rsp_rdata_a_q;
    rsp_rdata_b_d = rsp_rdata_b_q;
    if (ram_re_a_q) rsp_rdata_a_d = ram_dout_a;
    else            rsp_rdata_a_d = rsp_rdata_a_q;
    if (ram_re_b_q) rsp_rdata_b_d = ram_dout_b;
    else            rsp_rdata_b_d = rsp_rdata_b_q;
  end

  // State registers; reset also drops any in-flight read response.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pri_q         <= PRI_RST;
      hazard_cnt_q  <= {CNT_WIDTH{1'b0}};
      ram_addr_a_q  <= {ADDR_WIDTH{1'b0}};
      ram_addr_b_q  <= {ADDR_WIDTH{1'b0}};
      ram_din_a_q   <= {DATA_WIDTH{1'b0}};
      ram_din_b_q   <= {DATA_WIDTH{1'b0}};
      ram_we_a_q    <= 1'b0;
      ram_we_b_q    <= 1'b0;
      ram_re_a_q    <= 1'b0;
      ram_re_b_q    <= 1'b0;
      rsp_valid_a_q <= 1'b0;
      rsp_valid_b_q <= 1'b0;
      rsp_rdata_a_q <= {DATA_WIDTH{1'b0}};
      rsp_rdata_b_q <= {DATA_WIDTH{1'b0}};
    end else begin
      pri_q         <= pri_d;
      hazard_cnt_q  <= hazard_cnt_d;
      ram_addr_a_q  <= ram_addr_a_d;
      ram_addr_b_q  <= ram_addr_b_d;
      ram_din_a_q   <= ram_din_a_d;
      ram_din_b_q   <= ram_din_b_d;
      ram_we_a_q    <= ram_we_a_d;
      ram_we_b_q    <= ram_we_b_d;
      ram_re_a_q    <= ram_re_a_d;
      ram_re_b_q    <= ram_re_b_d;
      rsp_valid_a_q <= rsp_valid_a_d;
      rsp_valid_b_q <= rsp_valid_b_d;
      rsp_rdata_a_q <= rsp_rdata_a_d;
      rsp_rdata_b_q <= rsp_rdata_b_d;
    end
  end

  assign req_ready_a = ready_a_s;
  assign req_ready_b = ready_b_s;
  assign ram_addr_a  = ram_addr_a_q;
  assign ram_din_a   = ram_din_a_q;
  assign ram_we_a    = ram_we_a_q;
  assign ram_re_a    = ram_re_a_q;
  assign ram_addr_b  = ram_addr_b_q;
  assign ram_din_b   = ram_din_b_q;
  assign ram_we_b    = ram_we_b_q;
  assign ram_re_b    = ram_re_b_q;
  assign rsp_valid_a = rsp_valid_a_q;
  assign rsp_rdata_a = rsp_rdata_a_q;
  assign rsp_valid_b = rsp_valid_b_q;
  assign rsp_rdata_b = rsp_rdata_b_q;
  assign hazard_cnt  = hazard_cnt_q;

endmodule

// File: tb/tb_dpram_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dpram_access_arbiter
//
// Self-checking bench: a behavioural async dual-port RAM sits behind the DUT;
// a transaction-level reference model (golden memory array, round-robin
// winner bit, per-client response queues) predicts ready, RAM drive,
// responses and the hazard count. Directed scenarios are followed by random
// traffic and a counter-saturation run.
// -----------------------------------------------------------------------------
module tb_dpram_access_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 8;
  localparam bit A_FIRST = 1'b1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid_a, req_ready_a, req_we_a;
  logic [AW-1:0] req_addr_a;
  logic [DW-1:0] req_wdata_a;
  logic          rsp_valid_a;
  logic [DW-1:0] rsp_rdata_a;
  logic          req_valid_b, req_ready_b, req_we_b;
  logic [AW-1:0] req_addr_b;
  logic [DW-1:0] req_wdata_b;
  logic          rsp_valid_b;
  logic [DW-1:0] rsp_rdata_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
  logic          ram_we_a, ram_re_a, ram_we_b, ram_re_b;
  logic [CW-1:0] hazard_cnt;

  always #5 clk = ~clk;

  dpram_access_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .A_FIRST(A_FIRST)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_a(req_valid_a), .req_ready_a(req_ready_a), .req_we_a(req_we_a),
    .req_addr_a(req_addr_a), .req_wdata_a(req_wdata_a),
    .rsp_valid_a(rsp_valid_a), .rsp_rdata_a(rsp_rdata_a),
    .req_valid_b(req_valid_b), .req_ready_b(req_ready_b), .req_we_b(req_we_b),
    .req_addr_b(req_addr_b), .req_wdata_b(req_wdata_b),
    .rsp_valid_b(rsp_valid_b), .rsp_rdata_b(rsp_rdata_b),
    .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a), .ram_we_a(ram_we_a),
    .ram_re_a(ram_re_a), .ram_dout_a(ram_dout_a),
    .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b), .ram_we_b(ram_we_b),
    .ram_re_b(ram_re_b), .ram_dout_b(ram_dout_b),
    .hazard_cnt(hazard_cnt)
  );

  // Behavioural asynchronous dual-port RAM with sticky conflict flag.
  logic [DW-1:0] ram_mem [16] = '{default: 8'h00};
  bit            conflict_flag = 1'b0;
  assign ram_dout_a = ram_mem[ram_addr_a];
  assign ram_dout_b = ram_mem[ram_addr_b];

  always @(posedge clk) begin
    if (ram_we_a) ram_mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) ram_mem[ram_addr_b] <= ram_din_b;
    if ((ram_addr_a == ram_addr_b) &&
        ((ram_we_a && (ram_we_b || ram_re_b)) || (ram_we_b && ram_re_a)))
      conflict_flag <= 1'b1;
  end

  // Reference model state.
  typedef struct {
    int       due;
    bit [7:0] data;
  } rsp_t;

  rsp_t     qa[$], qb[$];
  bit [7:0] m_mem [16];
  bit       m_pri_a;
  int       m_cnt;
  bit [7:0] m_last_a, m_last_b;
  bit       m_we_a, m_re_a, m_we_b, m_re_b;
  bit [3:0] m_addr_a, m_addr_b;
  bit [7:0] m_din_a, m_din_b;
  bit       m_acc_a, m_acc_b;
  int       cyc;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock of stimulus, starting and ending at a falling edge.
  task automatic cycle(input bit rst,
                       input bit va, input bit wa, input bit [3:0] aa, input bit [7:0] da,
                       input bit vb, input bit wb, input bit [3:0] ab, input bit [7:0] db);
    bit       haz, ra, rb, exp_va, exp_vb;
    bit [7:0] rd_a, rd_b;
    reset_n = rst;
    req_valid_a = va; req_we_a = wa; req_addr_a = aa; req_wdata_a = da;
    req_valid_b = vb; req_we_b = wb; req_addr_b = ab; req_wdata_b = db;
    #1;
    haz = rst && va && vb && (aa == ab) && (wa || wb);
    ra  = rst && (!haz || m_pri_a);
    rb  = rst && (!haz || !m_pri_a);
    check_val("ready_a", req_ready_a, ra);
    check_val("ready_b", req_ready_b, rb);
    m_acc_a = va && ra;
    m_acc_b = vb && rb;
    rd_a = m_mem[aa];
    rd_b = m_mem[ab];
    if (!rst) begin
      qa.delete(); qb.delete();
      m_pri_a = A_FIRST; m_cnt = 0; m_last_a = 8'h00; m_last_b = 8'h00;
      m_we_a = 1'b0; m_re_a = 1'b0; m_we_b = 1'b0; m_re_b = 1'b0;
      m_addr_a = 4'h0; m_addr_b = 4'h0; m_din_a = 8'h00; m_din_b = 8'h00;
      m_acc_a = 1'b0; m_acc_b = 1'b0;
    end else begin
      if (haz) begin
        m_pri_a = !m_pri_a;
        if (m_cnt < 255) m_cnt++;
      end
      m_we_a = m_acc_a && wa; m_re_a = m_acc_a && !wa;
      m_we_b = m_acc_b && wb; m_re_b = m_acc_b && !wb;
      if (m_acc_a) begin m_addr_a = aa; m_din_a = da; end
      if (m_acc_b) begin m_addr_b = ab; m_din_b = db; end
      if (m_acc_a && !wa) qa.push_back('{cyc + 2, rd_a});
      if (m_acc_b && !wb) qb.push_back('{cyc + 2, rd_b});
      if (m_acc_a && wa) m_mem[aa] = da;
      if (m_acc_b && wb) m_mem[ab] = db;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_val("ram_we_a", ram_we_a, m_we_a);
    check_val("ram_re_a", ram_re_a, m_re_a);
    check_val("ram_we_b", ram_we_b, m_we_b);
    check_val("ram_re_b", ram_re_b, m_re_b);
    check_val("ram_addr_a", ram_addr_a, m_addr_a);
    check_val("ram_addr_b", ram_addr_b, m_addr_b);
    check_val("ram_din_a", ram_din_a, m_din_a);
    check_val("ram_din_b", ram_din_b, m_din_b);
    check_val("hazard_cnt", hazard_cnt, m_cnt);
    exp_va = (qa.size() > 0) && (qa[0].due == cyc);
    if (exp_va) begin m_last_a = qa[0].data; void'(qa.pop_front()); end
    exp_vb = (qb.size() > 0) && (qb[0].due == cyc);
    if (exp_vb) begin m_last_b = qb[0].data; void'(qb.pop_front()); end
    check_val("rsp_valid_a", rsp_valid_a, exp_va);
    check_val("rsp_rdata_a", rsp_rdata_a, m_last_a);
    check_val("rsp_valid_b", rsp_valid_b, exp_vb);
    check_val("rsp_rdata_b", rsp_rdata_b, m_last_b);
    check_val("ram_conflict", conflict_flag, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  initial begin
    int ia, ib, wta, wtb;
    cyc = 0;
    m_pri_a = A_FIRST;
    m_cnt = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    reset_n = 1'b0;
    req_valid_a = 1'b0; req_we_a = 1'b0; req_addr_a = 4'h0; req_wdata_a = 8'h00;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = 4'h0; req_wdata_b = 8'h00;
    @(negedge clk);

    // Reset: two edges with valids high, then release.
    cycle(1'b0, 1'b1, 1'b1, 4'h1, 8'hAA, 1'b1, 1'b1, 4'h1, 8'hBB);
    cycle(1'b0, 1'b1, 1'b1, 4'h1, 8'hAA, 1'b1, 1'b1, 4'h1, 8'hBB);
    idle(1);

    // Independent access on both ports.
    cycle(1'b1, 1'b1, 1'b1, 4'h3, 8'h5C, 1'b1, 1'b1, 4'h9, 8'h21);
    cycle(1'b1, 1'b1, 1'b0, 4'h9, 8'h00, 1'b1, 1'b0, 4'h3, 8'h00);
    idle(1);
    check_val("ind_rd_a", rsp_rdata_a, 32'h21);
    check_val("ind_rd_b", rsp_rdata_b, 32'h5C);

    // Write/write hazard: A wins, B holds and goes next.
    cycle(1'b1, 1'b1, 1'b1, 4'h7, 8'h11, 1'b1, 1'b1, 4'h7, 8'h22);
    check_val("ww_b_held", m_acc_b, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'h7, 8'h22);
    cycle(1'b1, 1'b1, 1'b0, 4'h7, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    idle(1);
    check_val("ww_rd", rsp_rdata_a, 32'h22);
    check_val("ww_cnt", hazard_cnt, 32'h1);

    // Fairness: both clients stream same-address writes and hold when refused.
    ia = 0; ib = 0; wta = 0; wtb = 0;
    for (int k = 0; k < 12 && (ia < 4 || ib < 4); k++) begin
      cycle(1'b1, ia < 4, 1'b1, 4'h5, 8'(8'hA0 + ia), ib < 4, 1'b1, 4'h5, 8'(8'hB0 + ib));
      if (ia < 4 && !m_acc_a) wta++; else wta = 0;
      if (ib < 4 && !m_acc_b) wtb++; else wtb = 0;
      check_val("fair_wait_a", wta <= 1, 1'b1);
      check_val("fair_wait_b", wtb <= 1, 1'b1);
      if (m_acc_a) ia++;
      if (m_acc_b) ib++;
    end
    check_val("fair_done", ia + ib, 32'd8);

    // Read/write same address with the pointer on B.
    if (m_pri_a) begin
      cycle(1'b1, 1'b1, 1'b1, 4'hF, 8'h01, 1'b1, 1'b1, 4'hF, 8'h02);
      cycle(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'hF, 8'h02);
    end
    cycle(1'b1, 1'b1, 1'b0, 4'h2, 8'h00, 1'b1, 1'b1, 4'h2, 8'h99);
    check_val("rw_a_held", m_acc_a, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 4'h2, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    idle(1);
    check_val("rw_rd_a", rsp_rdata_a, 32'h99);
    cycle(1'b1, 1'b1, 1'b0, 4'h2, 8'h00, 1'b1, 1'b0, 4'h2, 8'h00);
    check_val("rr_both", {m_acc_a, m_acc_b}, 2'b11);
    idle(1);
    check_val("rr_rd_b", rsp_rdata_b, 32'h99);

    // Random traffic on a narrow address range to provoke hazards.
    for (int k = 0; k < 400; k++) begin
      cycle(1'b1, 1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 8'($urandom),
                  1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 8'($urandom));
    end
    idle(2);

    // Reset while a read is in flight: no response may appear.
    cycle(1'b1, 1'b1, 1'b0, 4'h2, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    check_val("mid_rst_re_a", ram_re_a, 1'b0);
    idle(3);

    // Counter saturation under continuous hazards.
    for (int k = 0; k < 270; k++) begin
      cycle(1'b1, 1'b1, 1'b1, 4'h0, 8'(k), 1'b1, 1'b1, 4'h0, 8'(k + 1));
    end
    check_val("cnt_sat", hazard_cnt, 32'hFF);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
